// File: rtl/shift_seq_ctrl.sv
// Serial frame sequencer: drives one WIDTH-bit frame into an external shift register,
// then reads the register back in parallel and flags a mismatch with the sent image.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] sq_in,
  output logic             sd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hold;
  logic             hmode;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] expected;

  // LSB-first frames land in the register bit-reversed.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  always_ff @(posedge ck) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial bit select and state-decoded status.
  always_comb begin
    idx  = hmode ? cnt : (LAST - cnt);
    sd   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT: begin
        sd   = hold[idx];
        busy = 1'b1;
      end
      CAPTURE: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign expected = hmode ? bit_rev(hold) : hold;

  always_ff @(posedge ck) begin
    if (!res) begin
      hold  <= '0;
      hmode <= 1'b0;
      cnt   <= '0;
      dout  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            hold  <= din;
            hmode <= mode;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (abort || cnt == LAST) cnt <= '0;
          else                      cnt <= cnt + CW'(1);
        end
        CAPTURE: begin
          if (!abort) begin
            dout <= sq_in;
            err  <= (sq_in != expected);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl attached to a behavioural 4-bit shift register;
// a force flag can pin the register's parallel output to zero.
module tb_shift_seq_ctrl;

  localparam int unsigned W = 4;

  logic         ck;
  logic         res;
  logic         start;
  logic [W-1:0] din;
  logic         mode;
  logic         abort;
  logic [W-1:0] sq_in;
  logic         sd;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic         err;

  logic [W-1:0] sr = '0;
  logic         force_zero;

  int total = 0;
  int bad   = 0;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .ck(ck), .res(res), .start(start), .din(din), .mode(mode), .abort(abort),
    .sq_in(sq_in), .sd(sd), .busy(busy), .done(done), .dout(dout), .err(err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  always @(posedge ck) sr <= {sr[W-2:0], sd};
  assign sq_in = force_zero ? '0 : sr;

  typedef struct {
    logic [W-1:0] din;
    logic         mode;
    logic         force0;
    logic [W-1:0] exp_sd;   // bit W-1 is the first bit presented
    logic [W-1:0] exp_dout;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 16'(busy), 16'd0);
    check({tag, " done"}, 16'(done), 16'd0);
    check({tag, " sd"},   16'(sd),   16'd0);
    check({tag, " dout"}, 16'(dout), 16'd0);
    check({tag, " err"},  16'(err),  16'd0);
  endtask

  // Entered just after a falling edge with the DUT in IDLE; returns the same way.
  task automatic run_frame(input vec_t v, input string tag);
    force_zero = v.force0;
    start = 1'b1;
    din   = v.din;
    mode  = v.mode;
    @(negedge ck);
    start = 1'b0;
    din   = ~v.din;
    mode  = ~v.mode;
    for (int i = 0; i < int'(W); i++) begin
      check($sformatf("%s sd%0d", tag, i), 16'(sd), 16'(v.exp_sd[W-1-i]));
      check($sformatf("%s busy%0d", tag, i), 16'(busy), 16'd1);
      @(negedge ck);
    end
    check({tag, " cap sd"},   16'(sd),   16'd0);
    check({tag, " cap done"}, 16'(done), 16'd0);
    @(negedge ck);
    check({tag, " done"}, 16'(done), 16'd1);
    check({tag, " dout"}, 16'(dout), 16'(v.exp_dout));
    check({tag, " err"},  16'(err),  16'(v.exp_err));
    @(negedge ck);
    check({tag, " post done"}, 16'(done), 16'd0);
    check({tag, " post busy"}, 16'(busy), 16'd0);
    force_zero = 1'b0;
  endtask

  initial begin
    int ndone;
    int first_at;
    int second_at;

    vecs[0] = '{4'b1011, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0};
    vecs[1] = '{4'b1011, 1'b1, 1'b0, 4'b1101, 4'b1101, 1'b0};
    vecs[2] = '{4'b0110, 1'b0, 1'b1, 4'b0110, 4'b0000, 1'b1};
    vecs[3] = '{4'b1000, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0};
    vecs[4] = '{4'b0110, 1'b1, 1'b1, 4'b0110, 4'b0000, 1'b1};
    vecs[5] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{4'b1111, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0};

    res = 1'b0; start = 1'b1; din = 4'b1010; mode = 1'b0; abort = 1'b0; force_zero = 1'b0;
    repeat (3) @(negedge ck);
    check_idle_zero("reset");
    res = 1'b1;

    // First start right at reset release, then the vector table.
    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Abort on the second SHIFT cycle: previous result kept, no done.
    start = 1'b1; din = 4'b0101; mode = 1'b0;
    @(negedge ck);
    start = 1'b0;
    @(negedge ck);
    abort = 1'b1;
    @(negedge ck);
    abort = 1'b0;
    check("abort busy", 16'(busy), 16'd0);
    check("abort sd",   16'(sd),   16'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort done%0d", i), 16'(done), 16'd0);
      @(negedge ck);
    end
    check("abort dout", 16'(dout), 16'hf);
    check("abort err",  16'(err),  16'd0);

    // Abort in CAPTURE: capture suppressed.
    start = 1'b1; din = 4'b0101; mode = 1'b0;
    @(negedge ck);
    start = 1'b0;
    repeat (W) @(negedge ck);
    check("capab in cap", 16'(busy), 16'd1);
    abort = 1'b1;
    @(negedge ck);
    abort = 1'b0;
    check("capab busy", 16'(busy), 16'd0);
    check("capab done", 16'(done), 16'd0);
    check("capab dout", 16'(dout), 16'hf);

    // start together with abort in IDLE is refused.
    start = 1'b1; abort = 1'b1;
    @(negedge ck);
    start = 1'b0; abort = 1'b0;
    check("idle abort busy", 16'(busy), 16'd0);

    // Abort during DONE leaves the pulse and result intact.
    start = 1'b1; din = 4'b1000; mode = 1'b0;
    @(negedge ck);
    start = 1'b0;
    repeat (W + 1) @(negedge ck);
    abort = 1'b1;
    check("doneab done", 16'(done), 16'd1);
    check("doneab dout", 16'(dout), 16'h8);
    @(negedge ck);
    abort = 1'b0;
    check("doneab after", 16'(done), 16'd0);
    check("doneab dout2", 16'(dout), 16'h8);

    // Reset mid-SHIFT clears everything; next frame completes normally.
    start = 1'b1; din = 4'b0110; mode = 1'b0;
    @(negedge ck);
    start = 1'b0;
    @(negedge ck);
    res = 1'b0;
    @(negedge ck);
    check_idle_zero("midrst");
    res = 1'b1;
    run_frame(vecs[0], "postrst");

    // Start held high: one frame every W+3 cycles.
    ndone = 0; first_at = -1; second_at = -1;
    start = 1'b1; din = 4'b1011; mode = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge ck);
      if (done) begin
        ndone++;
        if (first_at < 0) first_at = c;
        else if (second_at < 0) second_at = c;
        check($sformatf("cont dout c%0d", c), 16'(dout), 16'hb);
      end
    end
    start = 1'b0;
    check("cont count", 16'(ndone), 16'd3);
    check("cont first", 16'(first_at), 16'(W + 2));
    check("cont period", 16'(second_at - first_at), 16'(W + 3));
    repeat (W + 3) @(negedge ck);
    check("cont idle", 16'(busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
